// File: rtl/mealy_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : mealy_pattern_gen_if
// Brief    : Control/status bundle between a burst requester and the
//            serial pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
interface mealy_pattern_gen_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 start;
    logic [CNT_WIDTH-1:0] rep_count;
    logic                 abort;
    logic                 out_bit;
    logic                 out_valid;
    logic                 frame_start;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output rep_count,
        output abort,
        input  out_bit,
        input  out_valid,
        input  frame_start,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rep_count,
        input  abort,
        output out_bit,
        output out_valid,
        output frame_start,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/mealy_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : mealy_pattern_gen
// Brief    : Serial burst transmitter: repeats PATTERN MSB-first for a latched
//            number of frames, with GAP_BITS idle cycles between frames.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_pattern_gen #(
    parameter int                   PAT_WIDTH  = 5,
    parameter logic [PAT_WIDTH-1:0] PATTERN    = 5'b11010,
    parameter int                   GAP_BITS   = 2,
    parameter logic                 IDLE_LEVEL = 1'b0,
    parameter int                   CNT_WIDTH  = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mealy_pattern_gen_if.slave bus
);

    localparam int                   c_IDX_W    = $clog2(PAT_WIDTH);
    localparam logic [c_IDX_W-1:0]   c_IDX_MSB  = c_IDX_W'(PAT_WIDTH - 1);
    localparam logic [3:0]           c_GAP_LOAD = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
    localparam logic [CNT_WIDTH-1:0] c_ONE_FRM  = CNT_WIDTH'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_IDX_W-1:0]   w_bit_idx_nxt;
    logic [3:0]           r_gap_cnt;
    logic [3:0]           w_gap_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_frames_left;
    logic [CNT_WIDTH-1:0] w_frames_left_nxt;

    logic                 w_frame_edge;
    logic                 w_burst_end;

    logic                 r_out_bit;
    logic                 r_out_valid;
    logic                 r_frame_start;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_out_bit_nxt;
    logic                 w_out_valid_nxt;
    logic                 w_frame_start_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_bit_idx     <= c_IDX_MSB;
            r_gap_cnt     <= 4'd0;
            r_frames_left <= '0;
            r_out_bit     <= IDLE_LEVEL;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_frames_left <= w_frames_left_nxt;
            r_out_bit     <= w_out_bit_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. r_frames_left counts the frame in flight, so a
    // value of one while on bit 0 marks the final frame of the burst.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_idx_nxt     = r_bit_idx;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_frames_left_nxt = r_frames_left;
        w_frame_edge      = 1'b0;
        w_burst_end       = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (!bus.abort && bus.start && (bus.rep_count != '0)) begin
                    w_state_nxt       = c_ST_SEND;
                    w_bit_idx_nxt     = c_IDX_MSB;
                    w_frames_left_nxt = bus.rep_count;
                    w_frame_edge      = 1'b1;
                end
            end

            c_ST_SEND: begin
                if (bus.abort) begin
                    w_state_nxt       = c_ST_IDLE;
                    w_bit_idx_nxt     = c_IDX_MSB;
                    w_frames_left_nxt = '0;
                end else if (r_bit_idx != '0) begin
                    w_bit_idx_nxt = r_bit_idx - 1'b1;
                end else if (r_frames_left > c_ONE_FRM) begin
                    w_frames_left_nxt = r_frames_left - 1'b1;
                    w_bit_idx_nxt     = c_IDX_MSB;
                    if (GAP_BITS > 0) begin
                        w_state_nxt   = c_ST_GAP;
                        w_gap_cnt_nxt = c_GAP_LOAD;
                    end else begin
                        w_frame_edge  = 1'b1;
                    end
                end else begin
                    w_state_nxt       = c_ST_IDLE;
                    w_bit_idx_nxt     = c_IDX_MSB;
                    w_frames_left_nxt = '0;
                    w_burst_end       = 1'b1;
                end
            end

            c_ST_GAP: begin
                if (bus.abort) begin
                    w_state_nxt       = c_ST_IDLE;
                    w_frames_left_nxt = '0;
                    w_gap_cnt_nxt     = 4'd0;
                end else if (r_gap_cnt == 4'd0) begin
                    w_state_nxt   = c_ST_SEND;
                    w_bit_idx_nxt = c_IDX_MSB;
                    w_frame_edge  = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt       = c_ST_IDLE;
                w_bit_idx_nxt     = c_IDX_MSB;
                w_gap_cnt_nxt     = 4'd0;
                w_frames_left_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: computed from the upcoming state so every output
    // leaves a flop and lines up with the bit it describes.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt        = (w_state_nxt != c_ST_IDLE);
        w_out_valid_nxt   = (w_state_nxt == c_ST_SEND);
        w_out_bit_nxt     = IDLE_LEVEL;
        w_frame_start_nxt = w_frame_edge;
        w_done_nxt        = w_burst_end;
        if (w_state_nxt == c_ST_SEND) begin
            w_out_bit_nxt = PATTERN[w_bit_idx_nxt];
        end
    end

    assign bus.out_bit     = r_out_bit;
    assign bus.out_valid   = r_out_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mealy_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_pattern_gen
// Brief    : Directed bench for mealy_pattern_gen (GAP_BITS=2 and GAP_BITS=0
//            builds side by side) with a cycle-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_pattern_gen;

    typedef logic [4:0] cyc_t;   // {out_bit, out_valid, frame_start, busy, done}
    typedef cyc_t cyc_q_t[$];

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start;
    logic [3:0] rep_count;
    logic       abort;

    int total = 0;
    int bad   = 0;

    logic [4:0] pat   = 5'b11010;
    logic [9:0] pat10 = 10'b1101011010;

    mealy_pattern_gen_if #(.CNT_WIDTH(4)) bus_a ();
    mealy_pattern_gen_if #(.CNT_WIDTH(4)) bus_b ();

    assign bus_a.start     = start;
    assign bus_a.rep_count = rep_count;
    assign bus_a.abort     = abort;
    assign bus_b.start     = start;
    assign bus_b.rep_count = rep_count;
    assign bus_b.abort     = abort;

    mealy_pattern_gen #(
        .PAT_WIDTH (5), .PATTERN (5'b11010), .GAP_BITS (2),
        .IDLE_LEVEL(1'b0), .CNT_WIDTH(4)
    ) u_dut_gap2 (.clk(clk), .reset(reset), .bus(bus_a));

    mealy_pattern_gen #(
        .PAT_WIDTH (5), .PATTERN (5'b11010), .GAP_BITS (0),
        .IDLE_LEVEL(1'b0), .CNT_WIDTH(4)
    ) u_dut_gap0 (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    // Mealy 11010 detector fed by the GAP_BITS=2 stream
    logic [3:0] hist;
    logic       det;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist <= 4'd0;
        else       hist <= {hist[2:0], bus_a.out_bit};
    end
    assign det = ({hist, bus_a.out_bit} == 5'b11010);

    // Expected per-cycle outputs of one burst
    function automatic cyc_q_t burst(input int n, input int gap);
        cyc_q_t q;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < 5; b++)
                q.push_back({pat[4-b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (f < n - 1)
                for (int g = 0; g < gap; g++) q.push_back(5'b00010);
        end
        q.push_back(5'b00001);
        return q;
    endfunction

    cyc_t   cur[2];
    cyc_q_t mq[2];
    int     gapv[2];

    initial begin
        gapv[0] = 2;
        gapv[1] = 0;
        cur[0]  = 5'b00000;
        cur[1]  = 5'b00000;
        forever begin
            @(posedge clk or posedge reset);
            for (int m = 0; m < 2; m++) begin
                if (reset) begin
                    mq[m].delete();
                    cur[m] = 5'b00000;
                end else if (cur[m][1]) begin
                    if (abort || mq[m].size() == 0) begin
                        mq[m].delete();
                        cur[m] = 5'b00000;
                    end else begin
                        cur[m] = mq[m].pop_front();
                    end
                end else if (!abort && start && rep_count != 4'd0) begin
                    mq[m]  = burst(int'(rep_count), gapv[m]);
                    cur[m] = mq[m].pop_front();
                end else begin
                    cur[m] = 5'b00000;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc_t act_a, act_b;
        act_a = {bus_a.out_bit, bus_a.out_valid, bus_a.frame_start, bus_a.busy, bus_a.done};
        act_b = {bus_b.out_bit, bus_b.out_valid, bus_b.frame_start, bus_b.busy, bus_b.done};
        total++;
        if (act_a !== cur[0]) begin
            bad++;
            $display("FAIL model_gap2 t=%0t got=%b expected=%b", $time, act_a, cur[0]);
        end
        total++;
        if (act_b !== cur[1]) begin
            bad++;
            $display("FAIL model_gap0 t=%0t got=%b expected=%b", $time, act_b, cur[1]);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Accepted at the next edge; returns in the first-bit cycle
    task automatic do_start(input logic [3:0] n);
        start     = 1'b1;
        rep_count = n;
        tick(1);
        start     = 1'b0;
    endtask

    initial begin
        int fs_cnt, done_cnt;
        start     = 1'b0;
        rep_count = 4'd0;
        abort     = 1'b0;
        tick(3);
        chk("rst_busy",  bus_a.busy, 0);
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_bit",   bus_a.out_bit, 0);
        chk("rst_done",  bus_a.done, 0);
        chk("rst_fs",    bus_a.frame_start, 0);
        reset = 1'b0;
        tick(2);

        // single frame
        do_start(4'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t1_bit",   bus_a.out_bit, pat[4-i]);
            chk("t1_valid", bus_a.out_valid, 1);
            chk("t1_fs",    bus_a.frame_start, (i == 0));
            tick(1);
        end
        chk("t1_done", bus_a.done, 1);
        chk("t1_busy", bus_a.busy, 0);
        tick(1);
        chk("t1_idle_bit",  bus_a.out_bit, 0);
        chk("t1_idle_done", bus_a.done, 0);
        tick(2);

        // three frames with gaps; detector must fire on each frame's last bit
        do_start(4'd3);
        for (int k = 1; k <= 20; k++) begin
            chk("t2_det", det, (k == 5 || k == 12 || k == 19));
            if (k == 6 || k == 7 || k == 13 || k == 14) chk("t2_gap_valid", bus_a.out_valid, 0);
            if (k == 8 || k == 15) chk("t2_fs", bus_a.frame_start, 1);
            if (k == 20) chk("t2_done", bus_a.done, 1);
            tick(1);
        end
        tick(2);

        // start and rep_count changes during a burst are ignored
        do_start(4'd2);
        tick(1);
        start     = 1'b1;
        rep_count = 4'd7;
        tick(1);
        start     = 1'b0;
        fs_cnt    = 0;
        done_cnt  = 0;
        for (int k = 0; k < 25; k++) begin
            fs_cnt   += int'(bus_a.frame_start);
            done_cnt += int'(bus_a.done);
            tick(1);
        end
        chk("t3_more_frames", 16'(fs_cnt), 1);
        chk("t3_done_count",  16'(done_cnt), 1);
        rep_count = 4'd0;

        // abort during bit 3, then immediate restart
        do_start(4'd1);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4_busy",  bus_a.busy, 0);
        chk("t4_valid", bus_a.out_valid, 0);
        chk("t4_done",  bus_a.done, 0);
        do_start(4'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_bit", bus_a.out_bit, pat[4-i]);
            tick(1);
        end
        chk("t4_done_after", bus_a.done, 1);
        tick(2);

        // asynchronous reset mid-frame
        do_start(4'd2);
        tick(1);
        #2 reset = 1'b1;
        #1;
        chk("t5_busy",  bus_a.busy, 0);
        chk("t5_valid", bus_a.out_valid, 0);
        chk("t5_fs",    bus_a.frame_start, 0);
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("t5_stay_idle", bus_a.busy, 0);

        // start with zero count, start together with abort
        do_start(4'd0);
        chk("t6_zero_busy", bus_a.busy, 0);
        tick(2);
        chk("t6_zero_done", bus_a.done, 0);
        start     = 1'b1;
        rep_count = 4'd3;
        abort     = 1'b1;
        tick(1);
        start     = 1'b0;
        abort     = 1'b0;
        chk("t6_abort_busy",  bus_a.busy, 0);
        chk("t6_abort_valid", bus_a.out_valid, 0);
        tick(1);

        // start held during the done cycle
        do_start(4'd1);
        tick(5);
        chk("t6_b2b_done", bus_a.done, 1);
        start     = 1'b1;
        rep_count = 4'd1;
        tick(1);
        start     = 1'b0;
        chk("t6_b2b_busy", bus_a.busy, 1);
        chk("t6_b2b_fs",   bus_a.frame_start, 1);
        chk("t6_b2b_bit",  bus_a.out_bit, 1);
        tick(7);

        // GAP_BITS=0 build: two frames back to back
        do_start(4'd2);
        for (int i = 0; i < 10; i++) begin
            chk("t7_g0_bit",   bus_b.out_bit, pat10[9-i]);
            chk("t7_g0_valid", bus_b.out_valid, 1);
            tick(1);
        end
        chk("t7_g0_done", bus_b.done, 1);
        tick(5);

        // largest burst the counter can express
        do_start(4'd15);
        fs_cnt   = 1;
        done_cnt = 0;
        for (int k = 0; k < 110; k++) begin
            tick(1);
            fs_cnt   += int'(bus_a.frame_start);
            done_cnt += int'(bus_a.done);
        end
        chk("t8_frames", 16'(fs_cnt), 15);
        chk("t8_done",   16'(done_cnt), 1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
